// File: rtl/sort_tx_pkg.sv
// Shared widths, FSM state encoding and frame type for the sorter back-end transmitter.
package sort_tx_pkg;
    localparam int DATA_W   = 8;
    localparam int NUM_ELEM = 8;
    localparam int IDX_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [NUM_ELEM*DATA_W-1:0] frame_t;
endpackage

// File: rtl/order_check.sv
// Flags a frame in which some adjacent pair decreases; only built when SORT_TX_CHECK_EN is defined.
`ifdef SORT_TX_CHECK_EN
module order_check
    import sort_tx_pkg::*;
#(
    parameter int ELEM_W = sort_tx_pkg::DATA_W,
    parameter int ELEMS  = sort_tx_pkg::NUM_ELEM
) (
    input  logic [ELEMS*ELEM_W-1:0] frame,
    output logic                    viol
);
    logic [ELEMS-2:0] pair_bad;

    generate
        for (genvar gi = 0; gi < ELEMS - 1; gi++) begin : g_pair
            assign pair_bad[gi] = frame[gi*ELEM_W +: ELEM_W] > frame[(gi+1)*ELEM_W +: ELEM_W];
        end
    endgenerate

    assign viol = |pair_bad;
endmodule
`endif

// File: rtl/sort_frame_tx.sv
// Registers one sorted frame and streams it out byte-serially, ascending or descending.
// Optional order checker on accept is enabled with SORT_TX_CHECK_EN.
module sort_frame_tx
    import sort_tx_pkg::*;
#(
    parameter int DATA_W   = sort_tx_pkg::DATA_W,
    parameter int NUM_ELEM = sort_tx_pkg::NUM_ELEM
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_ELEM*DATA_W-1:0] in_data,
    input  logic                       in_desc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       sort_err
);
    state_t             state_reg;
    logic [IDX_W-1:0]   cnt_reg;
    logic               desc_reg;
    logic               valid_reg;
    logic               last_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [DATA_W-1:0]  frame_reg [NUM_ELEM];
    logic [DATA_W-1:0]  in_elem   [NUM_ELEM];

    logic               accept;
    logic               beat;
    logic               viol;
    logic [IDX_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   sel_next;

    generate
        for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_unpack
            assign in_elem[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef SORT_TX_CHECK_EN
    order_check #(
        .ELEM_W (DATA_W),
        .ELEMS  (NUM_ELEM)
    ) u_order_check (
        .frame (in_data),
        .viol  (viol)
    );
`else
    assign viol = 1'b0;
`endif

    // in_ready may follow out_ready only on the last beat, so frames can abut.
    assign beat     = valid_reg && out_ready;
    assign in_ready = (state_reg == IDLE) || (beat && last_reg);
    assign accept   = in_valid && in_ready;

    // The next beat's element is fetched one cycle early so out_data stays a flop.
    assign cnt_next = cnt_reg + 1'b1;
    assign sel_next = desc_reg ? (IDX_W'(NUM_ELEM - 1) - cnt_next) : cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            desc_reg  <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                frame_reg[i] <= '0;
            end
        end else if (accept) begin
            state_reg <= SEND;
            cnt_reg   <= '0;
            desc_reg  <= in_desc;
            valid_reg <= 1'b1;
            last_reg  <= 1'b0;
            err_reg   <= viol;
            data_reg  <= in_desc ? in_elem[NUM_ELEM-1] : in_elem[0];
            for (int i = 0; i < NUM_ELEM; i++) begin
                frame_reg[i] <= in_elem[i];
            end
        end else if (beat) begin
            if (last_reg) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
            end else begin
                cnt_reg  <= cnt_next;
                last_reg <= (cnt_next == IDX_W'(NUM_ELEM - 1));
                data_reg <= frame_reg[sel_next];
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_idx   = cnt_reg;
    assign out_last  = last_reg;
    assign busy      = (state_reg == SEND);
    assign sort_err  = err_reg;
endmodule

// File: tb/tb_sort_frame_tx.sv
// Bench for sort_frame_tx: directed scenarios plus random frames against a beat-queue model.
module tb_sort_frame_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_desc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        sort_err;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    beat_t q[$];
    logic  exp_err;
    int    checks = 0;
    int    errors = 0;
    int    idx3_cycles;
    int    valid_cycles;

    sort_frame_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .sort_err  (sort_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic unsorted(input logic [63:0] f);
        logic r = 1'b0;
        for (int i = 0; i < 7; i++)
            if (f[i*8 +: 8] > f[(i+1)*8 +: 8]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] sorted_rand();
        logic [7:0]  v[8];
        logic [7:0]  t;
        logic [63:0] f;
        for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
        for (int i = 1; i < 8; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = v[i];
        return f;
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic step();
        logic  xfer;
        logic  rdy;
        logic  acc;
        beat_t b;
        @(negedge clk);
        xfer = (q.size() != 0) && out_ready;
        rdy  = (q.size() == 0) || (xfer && q[0].last);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(rdy));
        chk("busy",      32'(busy),      32'(q.size() != 0));
        chk("sort_err",  32'(sort_err),  32'(exp_err));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_idx",  32'(out_idx),  32'(q[0].idx));
            chk("out_last", 32'(out_last), 32'(q[0].last));
            if (out_idx == 3'd3) idx3_cycles++;
            valid_cycles++;
        end
        acc = in_valid && rdy;
        @(posedge clk);
        if (xfer) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                int e;
                e = in_desc ? 7 - k : k;
                b.data = in_data[e*8 +: 8];
                b.idx  = 3'(k);
                b.last = (k == 7);
                q.push_back(b);
            end
`ifdef SORT_TX_CHECK_EN
            exp_err = unsorted(in_data);
`else
            exp_err = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic send_simple(input logic [63:0] f, input logic d);
        in_data  = f;
        in_desc  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = ~f;
        for (int i = 0; i < 9; i++) step();
    endtask

    initial begin
        logic [63:0] fa;
        logic [63:0] fb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_desc   = 1'b0;
        out_ready = 1'b0;
        exp_err   = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_idx",   32'(out_idx),   0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_sort_err",  32'(sort_err),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fa = 64'hFF7F302210090501;
        out_ready = 1'b1;
        send_simple(fa, 1'b0);
        $display("ascending frame done, checks=%0d errors=%0d", checks, errors);
        send_simple(fa, 1'b1);
        $display("descending frame done, checks=%0d errors=%0d", checks, errors);

        // Backpressure while beat 3 is presented.
        idx3_cycles = 0;
        in_data = fa; in_desc = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0; step(); step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("beat3_hold_cycles", 32'(idx3_cycles), 3);
        chk("bp_drained", 32'(q.size()), 0);
        $display("backpressure frame done, checks=%0d errors=%0d", checks, errors);

        // Back-to-back: second frame waits on in_valid while the first is sent.
        fb = sorted_rand();
        in_data = fa; in_desc = 1'b0; in_valid = 1'b1;
        step();
        in_data = fb; in_desc = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("b2b_valid_cycles", 32'(valid_cycles), 16);
        step();
        chk("b2b_drained", 32'(q.size()), 0);
        $display("back-to-back frames done, checks=%0d errors=%0d", checks, errors);

        // Reset after beat 4 has transferred.
        in_data = fb; in_desc = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready",  32'(in_ready),  1);
        chk("midrst_busy",      32'(busy),      0);
        q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_simple(fa, 1'b1);
        $display("reset mid-frame done, checks=%0d errors=%0d", checks, errors);

        send_simple(64'h7060504030052010, 1'b0);
        $display("unsorted frame done, sort_err=%0b checks=%0d errors=%0d", sort_err, checks, errors);
        send_simple(fa, 1'b0);
        $display("sorted frame after unsorted done, checks=%0d errors=%0d", checks, errors);

        // Random frames, directions, gaps and backpressure.
        for (int n = 0; n < 40; n++) begin
            in_data  = ($urandom_range(0, 1) != 0) ? sorted_rand() : {$urandom, $urandom};
            in_desc  = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 30; c++) begin
                step();
                if (q.size() == 0 || c > 20) begin
                    in_valid = 1'b0;
                    break;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (q.size() <= 1) in_valid = ($urandom_range(0, 1) != 0);
            end
            $display("random round %0d, checks=%0d errors=%0d", n, checks, errors);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() != 0; c++) step();
        chk("final_drained", 32'(q.size()), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
